read_burst_splitter: RTL

- Command stage directly upstream of the RAM-like read engine.
- Accepts one read command (start word address, total length in words) over a valid/ready handshake. Splits it into bursts of at most MAX_BURST words and drives the engine's start/address/length inputs for one burst at a time.
- Counts the engine's returned read-valid beats itself, so completion does not depend on forward-path or return-path latency.
- Pulses a done flag once every word of the command has returned.

---
 rtl/read_burst_splitter_pkg.sv | 19 +
 rtl/read_burst_splitter_if.sv | 31 +++
 rtl/read_burst_splitter_beat_counter.sv | 34 +++
 rtl/read_burst_splitter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/read_burst_splitter_pkg.sv
// Shared types, default widths and helpers for the read burst splitter.
package read_burst_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 32;
   localparam int unsigned DEF_LEN_WIDTH  = 32;
   localparam int unsigned DEF_MAX_BURST  = 256;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_e;

   function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/read_burst_splitter_if.sv
// Command-side and engine-side signals of the read burst splitter.
interface read_burst_splitter_if
   import read_burst_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
);
   logic                  CMD_VALID;
   logic                  CMD_READY;
   logic [ADDR_WIDTH-1:0] CMD_ADDR;
   logic [LEN_WIDTH-1:0]  CMD_LENGTH;
   logic                  CMD_DONE;
   logic                  BUSY;
   logic                  STRAY_RVALID;
   logic                  READ_START;
   logic [ADDR_WIDTH-1:0] RADDR_START;
   logic [31:0]           READ_LENGTH;
   logic                  RVALID_COPY;

   // Command issuer and read engine
   modport master (
      output CMD_VALID, CMD_ADDR, CMD_LENGTH, RVALID_COPY,
      input  CMD_READY, CMD_DONE, BUSY, STRAY_RVALID, READ_START, RADDR_START, READ_LENGTH
   );

   // The splitter itself
   modport slave (
      input  CMD_VALID, CMD_ADDR, CMD_LENGTH, RVALID_COPY,
      output CMD_READY, CMD_DONE, BUSY, STRAY_RVALID, READ_START, RADDR_START, READ_LENGTH
   );
endinterface

// File: rtl/read_burst_splitter_beat_counter.sv
// Counts returned beats of one burst; saturates at the target.
module burst_beat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] count,
   output logic             last
);
   logic [WIDTH-1:0] count_q, count_d;
   logic             full;

   // Next count and last-beat flag (includes a beat arriving this cycle)
   always_comb begin
      full    = (count_q == target);
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (en && !full)
         count_d = count_q + WIDTH'(1);
      last = full || (en && ((count_q + WIDTH'(1)) == target));
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/read_burst_splitter.sv
// Splits one read command into engine bursts of at most MAX_BURST words.
module read_burst_splitter
   import read_burst_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
   parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
   input logic                  CLK,
   input logic                  RSTN,
   read_burst_splitter_if.slave bus
);
   if (LEN_WIDTH < 1 || LEN_WIDTH > 32) begin : g_bad_len_width
      $error("LEN_WIDTH must be in 1..32");
   end
   if (MAX_BURST < 1 || (64'(MAX_BURST) >> LEN_WIDTH) != 64'd0) begin : g_bad_max_burst
      $error("MAX_BURST must be in 1..2^LEN_WIDTH-1");
   end

   localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_BURST);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [LEN_WIDTH-1:0]  burst_len_q, burst_len_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  busy_q, busy_d;
   logic                  cmd_done_q, cmd_done_d;
   logic                  read_start_q, read_start_d;
   logic                  stray_q, stray_d;
   logic [LEN_WIDTH-1:0]  rem_next;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic                  bcnt_clear, bcnt_en, beat_last;
   logic [LEN_WIDTH-1:0]  beat_cnt;

   assign bcnt_en = bus.RVALID_COPY && ((state_q == ISSUE) || (state_q == WAIT));

   burst_beat_counter #(.WIDTH(LEN_WIDTH)) u_beat_counter (
      .clk    (CLK),
      .rst_n  (RSTN),
      .clear  (bcnt_clear),
      .en     (bcnt_en),
      .target (burst_len_q),
      .count  (beat_cnt),
      .last   (beat_last)
   );

   // Next-state, burst bookkeeping and registered-output values
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      burst_len_d = burst_len_q;
      raddr_d     = raddr_q;
      bcnt_clear  = 1'b0;
      rem_next    = remaining_q - burst_len_q;
      addr_next   = cur_addr_q + ADDR_WIDTH'(burst_len_q);
      stray_d     = stray_q | (bus.RVALID_COPY &&
                    ((state_q == IDLE) || (state_q == DONE) ||
                     ((state_q == WAIT) && (beat_cnt == burst_len_q))));
      unique case (state_q)
         IDLE: begin
            if (bus.CMD_VALID && cmd_ready_q) begin
               cur_addr_d  = bus.CMD_ADDR;
               remaining_d = bus.CMD_LENGTH;
               if (bus.CMD_LENGTH == '0) begin
                  state_d = DONE;
               end else begin
                  state_d     = ISSUE;
                  burst_len_d = LEN_WIDTH'(min_len(32'(bus.CMD_LENGTH), 32'(MAX_L)));
                  raddr_d     = bus.CMD_ADDR;
                  bcnt_clear  = 1'b1;
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (beat_last) begin
               remaining_d = rem_next;
               cur_addr_d  = addr_next;
               if (rem_next == '0) begin
                  state_d = DONE;
               end else begin
                  state_d     = ISSUE;
                  burst_len_d = LEN_WIDTH'(min_len(32'(rem_next), 32'(MAX_L)));
                  raddr_d     = addr_next;
                  bcnt_clear  = 1'b1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Outputs are registered, so derive them from the state being entered
      cmd_ready_d  = (state_d == IDLE);
      busy_d       = (state_d != IDLE);
      cmd_done_d   = (state_d == DONE);
      read_start_d = (state_d == ISSUE);
   end

   // FSM state, datapath registers and registered outputs
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q      <= IDLE;
         cur_addr_q   <= '0;
         remaining_q  <= '0;
         burst_len_q  <= '0;
         raddr_q      <= '0;
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         cmd_done_q   <= 1'b0;
         read_start_q <= 1'b0;
         stray_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         remaining_q  <= remaining_d;
         burst_len_q  <= burst_len_d;
         raddr_q      <= raddr_d;
         cmd_ready_q  <= cmd_ready_d;
         busy_q       <= busy_d;
         cmd_done_q   <= cmd_done_d;
         read_start_q <= read_start_d;
         stray_q      <= stray_d;
      end
   end

   assign bus.CMD_READY    = cmd_ready_q;
   assign bus.CMD_DONE     = cmd_done_q;
   assign bus.BUSY         = busy_q;
   assign bus.STRAY_RVALID = stray_q;
   assign bus.READ_START   = read_start_q;
   assign bus.RADDR_START  = raddr_q;
   assign bus.READ_LENGTH  = 32'(burst_len_q);
endmodule
